// File: rtl/jt12_timer_pkg.sv
// Shared geometry constants for the jt12 timer bank family.
// Timer A is a 10-bit unprescaled counter; timer B is an 8-bit counter
// that advances once per 16 sample ticks.
package jt12_timer_pkg;

  localparam int TA_CW = 10;
  localparam int TB_CW = 8;
  localparam int TB_PW = 4;

  // Default bank geometry: timer A width, timer B prescaler depth.
  localparam int DEF_N  = 2;
  localparam int DEF_CW = TA_CW;
  localparam int DEF_PW = TB_PW;

endpackage

// File: rtl/jt12_timer_bank_ch.sv
// One timer channel: reloadable up-counter with run/one-shot control,
// a registered one-clock overflow pulse and a sticky overflow flag.
import jt12_timer_pkg::*;

module jt12_timer_ch #(
  parameter int   CW        = TA_CW,
  parameter logic PRESCALED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          pre_wrap,
  input  logic [CW-1:0] start_value,
  input  logic          load,
  input  logic          oneshot,
  input  logic          clr_flag,
  output logic [CW-1:0] cnt,
  output logic          flag,
  output logic          overflow
);

  logic last_load;
  logic running;
  logic adv;
  logic at_top;

  // A prescaled channel only moves on the shared prescaler wrap tick.
  assign adv    = tick & running & (PRESCALED ? pre_wrap : 1'b1);
  assign at_top = &cnt;

  // Counter, run state and overflow pulse; a load rising edge outranks an advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      last_load <= 1'b0;
      running   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (tick) begin
        last_load <= load;
        if (load && !last_load) begin
          cnt     <= start_value;
          running <= 1'b1;
        end else if (!load) begin
          running <= 1'b0;
        end else if (adv) begin
          if (at_top) begin
            cnt      <= start_value;
            overflow <= 1'b1;
            running  <= !oneshot;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

  // Sticky flag runs every clock; a clear coinciding with the pulse drops the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (clr_flag) begin
      flag <= 1'b0;
    end else if (overflow) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/jt12_timer_bank.sv
// Bank of N independent FM timers sharing one sample tick and one
// free-running prescaler, with a combined active-low interrupt.
import jt12_timer_pkg::*;

module jt12_timer_bank #(
  parameter int           N        = DEF_N,
  parameter int           CW       = DEF_CW,
  parameter int           PW       = DEF_PW,
  parameter logic [N-1:0] PRE_MASK = 2'b10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            zero,
  input  logic [N*CW-1:0] start_value,
  input  logic [N-1:0]    load,
  input  logic [N-1:0]    oneshot,
  input  logic [N-1:0]    clr_flag,
  input  logic [N-1:0]    irq_en,
  output logic [N-1:0]    flag,
  output logic [N-1:0]    overflow,
  output logic [N*CW-1:0] count,
  output logic            irq_n
);

  logic          tick;
  logic [PW-1:0] free_cnt;
  logic          pre_wrap;

  assign tick     = cen & zero;
  assign pre_wrap = tick & (&free_cnt);

  // Free-running prescaler shared by every prescaled channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt <= '0;
    end else if (tick) begin
      free_cnt <= free_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    jt12_timer_ch #(
      .CW        (CW),
      .PRESCALED (PRE_MASK[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .pre_wrap    (pre_wrap),
      .start_value (start_value[i*CW +: CW]),
      .load        (load[i]),
      .oneshot     (oneshot[i]),
      .clr_flag    (clr_flag[i]),
      .cnt         (count[i*CW +: CW]),
      .flag        (flag[i]),
      .overflow    (overflow[i])
    );
  end

  assign irq_n = ~|(flag & irq_en);

endmodule
